// File: rtl/mem_stage_dmem_ctrl.sv
// MEM-stage data-memory controller: dcache handshake, pipeline stall,
// store lane formatting and load alignment/extension for the RV32I core.
module mem_stage_dmem_ctrl #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       rs2_data,
  output logic              data_read,
  output logic              data_write,
  output logic [31:0]       data_addr,
  output logic [3:0]        data_mbe,
  output logic [31:0]       data_wdata,
  input  logic              data_resp,
  input  logic [31:0]       data_rdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign,
  output logic [PERF_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r;
  logic [PERF_W-1:0] stall_cycles_r;
  logic              mem_op_s;
  logic              illegal_s;
  logic              unaligned_s;
  logic              req_s;
  logic              stall_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;

  assign mem_op_s = valid & (mem_read | mem_write);
  assign req_s    = mem_op_s & ~misalign;
  assign stall_s  = req_s & ~data_resp;

  // Legality and alignment of the access; reads win when both ops are set.
  always_comb begin
    illegal_s   = 1'b0;
    unaligned_s = 1'b0;
    if (mem_read) begin
      illegal_s = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    end else if (mem_write) begin
      illegal_s = (funct3 > 3'b010);
    end else begin
      illegal_s = 1'b0;
    end
    case (funct3[1:0])
      2'b01:   unaligned_s = addr[0];
      2'b10:   unaligned_s = (addr[1:0] != 2'b00);
      default: unaligned_s = 1'b0;
    endcase
    misalign = mem_op_s & (illegal_s | unaligned_s);
  end

  // Request, address and store-lane formatting.
  always_comb begin
    data_read  = req_s & mem_read;
    data_write = req_s & mem_write & ~mem_read;
    data_addr  = 32'h0000_0000;
    data_mbe   = 4'b0000;
    data_wdata = 32'h0000_0000;
    if (req_s) begin
      data_addr = {addr[31:2], 2'b00};
    end else begin
      data_addr = 32'h0000_0000;
    end
    if (data_write) begin
      case (funct3)
        3'b000: begin
          data_mbe   = 4'b0001 << addr[1:0];
          data_wdata = {4{rs2_data[7:0]}};
        end
        3'b001: begin
          data_mbe   = 4'b0011 << {addr[1], 1'b0};
          data_wdata = {2{rs2_data[15:0]}};
        end
        3'b010: begin
          data_mbe   = 4'b1111;
          data_wdata = rs2_data;
        end
        default: begin
          data_mbe   = 4'b0000;
          data_wdata = 32'h0000_0000;
        end
      endcase
    end else begin
      data_mbe   = 4'b0000;
      data_wdata = 32'h0000_0000;
    end
  end

  // Load lane selection and sign/zero extension.
  always_comb begin
    load_valid = data_resp & mem_read & req_s;
    byte_s     = data_rdata[8*addr[1:0] +: 8];
    half_s     = addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    load_data  = 32'h0000_0000;
    if (load_valid) begin
      case (funct3)
        3'b000:  load_data = {{24{byte_s[7]}}, byte_s};
        3'b001:  load_data = {{16{half_s[15]}}, half_s};
        3'b010:  load_data = data_rdata;
        3'b100:  load_data = {24'h00_0000, byte_s};
        3'b101:  load_data = {16'h0000, half_s};
        default: load_data = 32'h0000_0000;
      endcase
    end else begin
      load_data = 32'h0000_0000;
    end
  end

  assign stall        = stall_s;
  assign stall_cycles = stall_cycles_r;

  // Access FSM and saturating stall counter; a flush drops BUSY so nothing hangs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      stall_cycles_r <= {PERF_W{1'b0}};
    end else begin
      case (state_r)
        IDLE:    state_r <= (req_s & ~data_resp) ? BUSY : IDLE;
        BUSY:    state_r <= (data_resp | ~req_s) ? IDLE : BUSY;
        default: state_r <= IDLE;
      endcase
      if (stall_s && (stall_cycles_r != {PERF_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

endmodule
